// File: rtl/sys_bus_arb_pkg.sv
// Shared types for the two-requester system-bus arbiter.
package sys_bus_arb_pkg;

   localparam int ARB_DW = 64;
   localparam int ARB_AW = 32;
   localparam int ARB_SW = ARB_DW / 8;

   typedef enum logic {IDLE, WAIT} state_t;
   typedef enum logic {OP_RD, OP_WR} op_t;

   typedef struct packed {
      logic              pending;
      op_t               op;
      logic [ARB_AW-1:0] addr;
      logic [ARB_DW-1:0] wdata;
      logic [ARB_SW-1:0] sel;
   } slot_t;

endpackage

// File: rtl/sys_req_slot.sv
// One-deep request holding slot; a pulse arriving while occupied is dropped.
module sys_req_slot
   import sys_bus_arb_pkg::*;
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              wen,
   input  logic              ren,
   input  logic              clr,
   input  logic [ARB_AW-1:0] addr,
   input  logic [ARB_DW-1:0] wdata,
   input  logic [ARB_SW-1:0] sel,
   output slot_t             slot
);

   // clr only arrives while pending, so a coincident pulse is dropped anyway
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         slot <= '0;
      end else if (clr) begin
         slot.pending <= 1'b0;
      end else if (!slot.pending && (wen || ren)) begin
         slot.pending <= 1'b1;
         slot.op      <= wen ? OP_WR : OP_RD;
         slot.addr    <= addr;
         slot.wdata   <= wdata;
         slot.sel     <= sel;
      end
   end

endmodule

// File: rtl/sys_bus_arbiter.sv
// Round-robin arbiter serializing two requesters onto one system-bus target,
// with per-access response timeout.
module sys_bus_arbiter
   import sys_bus_arb_pkg::*;
#(
   parameter int AXI_DW  = ARB_DW,
   parameter int AXI_AW  = ARB_AW,
   parameter int AXI_SW  = AXI_DW / 8,
   parameter int TIMEOUT = 64
) (
   input  logic                axi_clk_i,
   input  logic                axi_rstn_i,
   input  logic [2*AXI_AW-1:0] req_addr_i,
   input  logic [2*AXI_DW-1:0] req_wdata_i,
   input  logic [2*AXI_SW-1:0] req_sel_i,
   input  logic [1:0]          req_wen_i,
   input  logic [1:0]          req_ren_i,
   output logic [1:0]          req_ack_o,
   output logic [1:0]          req_err_o,
   output logic [AXI_DW-1:0]   req_rdata_o,
   output logic [AXI_AW-1:0]   sys_addr_o,
   output logic [AXI_DW-1:0]   sys_wdata_o,
   output logic [AXI_SW-1:0]   sys_sel_o,
   output logic                sys_wen_o,
   output logic                sys_ren_o,
   input  logic [AXI_DW-1:0]   sys_rdata_i,
   input  logic                sys_err_i,
   input  logic                sys_ack_i
);

   localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
   localparam logic [CW-1:0] TMO_LAST = (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : '0;

   slot_t          slot [2];
   logic [1:0]     pend;
   logic [1:0]     clr;
   state_t         state_q, state_d;
   logic           gnt_q, gnt_d;
   logic           last_grant_q;
   logic [CW-1:0]  wait_cnt_q;
   logic           tmo_q;
   logic           issue, done, done_err;
   slot_t          iss, cur;

   for (genvar i = 0; i < 2; i++) begin : g_slot
      sys_req_slot u_slot (
         .clk   (axi_clk_i),
         .rst_n (axi_rstn_i),
         .wen   (req_wen_i[i]),
         .ren   (req_ren_i[i]),
         .clr   (clr[i]),
         .addr  (req_addr_i[i*AXI_AW +: AXI_AW]),
         .wdata (req_wdata_i[i*AXI_DW +: AXI_DW]),
         .sel   (req_sel_i[i*AXI_SW +: AXI_SW]),
         .slot  (slot[i])
      );
   end

   assign pend = {slot[1].pending, slot[0].pending};
   assign iss  = slot[gnt_d];
   assign cur  = slot[gnt_q];
   assign clr  = {2{done}} & {gnt_q, ~gnt_q};

   always_comb begin
      state_d  = state_q;
      gnt_d    = gnt_q;
      issue    = 1'b0;
      done     = 1'b0;
      done_err = 1'b0;
      case (state_q)
         IDLE: begin
            if (|pend) begin
               issue   = 1'b1;
               gnt_d   = (&pend) ? ~last_grant_q : pend[1];
               state_d = WAIT;
            end
         end
         WAIT: begin
            if (sys_ack_i) begin
               done     = 1'b1;
               done_err = sys_err_i;
               state_d  = IDLE;
            end else if (tmo_q) begin
               done     = 1'b1;
               done_err = 1'b1;
               state_d  = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge axi_clk_i or negedge axi_rstn_i) begin
      if (!axi_rstn_i) begin
         state_q <= IDLE;
         gnt_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         gnt_q   <= gnt_d;
      end
   end

   // tmo_q is a registered terminal-count flag, which puts the error
   // completion one cycle after wait_cnt reaches TIMEOUT-1
   always_ff @(posedge axi_clk_i or negedge axi_rstn_i) begin
      if (!axi_rstn_i) begin
         last_grant_q <= 1'b1;
         wait_cnt_q   <= '0;
         tmo_q        <= 1'b0;
         sys_addr_o   <= '0;
         sys_wdata_o  <= '0;
         sys_sel_o    <= '0;
         sys_wen_o    <= 1'b0;
         sys_ren_o    <= 1'b0;
         req_ack_o    <= '0;
         req_err_o    <= '0;
         req_rdata_o  <= '0;
      end else begin
         sys_wen_o <= issue && (iss.op == OP_WR);
         sys_ren_o <= issue && (iss.op == OP_RD);
         if (issue) begin
            sys_addr_o  <= iss.addr;
            sys_wdata_o <= iss.wdata;
            sys_sel_o   <= iss.sel;
            wait_cnt_q  <= '0;
         end else if (state_q == WAIT) begin
            wait_cnt_q <= wait_cnt_q + 1'b1;
         end
         tmo_q <= (TIMEOUT != 0) && (state_q == WAIT) && !sys_ack_i && !tmo_q
                  && (wait_cnt_q == TMO_LAST);
         req_ack_o   <= clr;
         req_err_o   <= done_err ? clr : 2'b00;
         req_rdata_o <= (done && sys_ack_i && (cur.op == OP_RD)) ? sys_rdata_i : '0;
         if (done) last_grant_q <= gnt_q;
      end
   end

endmodule

// File: tb/tb_sys_bus_arbiter.sv
// Directed bench for sys_bus_arbiter: per-cycle vector table plus corner sequences.
module tb_sys_bus_arbiter;

   logic          clk = 1'b0;
   logic          rst_n = 1'b1;
   logic [63:0]   req_addr_i = '0;
   logic [127:0]  req_wdata_i = '0;
   logic [15:0]   req_sel_i = {8'h0F, 8'hFF};
   logic [1:0]    req_wen_i = '0;
   logic [1:0]    req_ren_i = '0;
   logic [1:0]    req_ack_o, req_err_o;
   logic [63:0]   req_rdata_o;
   logic [31:0]   sys_addr_o;
   logic [63:0]   sys_wdata_o;
   logic [7:0]    sys_sel_o;
   logic          sys_wen_o, sys_ren_o;
   logic [63:0]   sys_rdata_i = '0;
   logic          sys_err_i = 1'b0;
   logic          sys_ack_i = 1'b0;

   int checks = 0;
   int errors = 0;

   sys_bus_arbiter #(.AXI_DW(64), .AXI_AW(32), .AXI_SW(8), .TIMEOUT(8)) dut (
      .axi_clk_i   (clk),
      .axi_rstn_i  (rst_n),
      .req_addr_i  (req_addr_i),
      .req_wdata_i (req_wdata_i),
      .req_sel_i   (req_sel_i),
      .req_wen_i   (req_wen_i),
      .req_ren_i   (req_ren_i),
      .req_ack_o   (req_ack_o),
      .req_err_o   (req_err_o),
      .req_rdata_o (req_rdata_o),
      .sys_addr_o  (sys_addr_o),
      .sys_wdata_o (sys_wdata_o),
      .sys_sel_o   (sys_sel_o),
      .sys_wen_o   (sys_wen_o),
      .sys_ren_o   (sys_ren_o),
      .sys_rdata_i (sys_rdata_i),
      .sys_err_i   (sys_err_i),
      .sys_ack_i   (sys_ack_i)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [1:0]  wen, ren;
      logic [31:0] a0, a1;
      logic [63:0] wd0;
      logic        ack, err;
      logic [63:0] rd;
      logic        e_wen, e_ren;
      logic [31:0] e_addr;
      logic [63:0] e_wdata;
      logic [7:0]  e_sel;
      logic [1:0]  e_ack, e_err;
      logic [63:0] e_rdata;
   } vec_t;

   localparam int NV = 19;
   vec_t tbl [NV];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic si(input int i, input logic [1:0] wen, input logic [1:0] ren,
                     input logic [31:0] a0, input logic [31:0] a1, input logic [63:0] wd0,
                     input logic ack, input logic err, input logic [63:0] rd);
      tbl[i].wen = wen; tbl[i].ren = ren; tbl[i].a0 = a0; tbl[i].a1 = a1;
      tbl[i].wd0 = wd0; tbl[i].ack = ack; tbl[i].err = err; tbl[i].rd = rd;
   endtask

   task automatic sx(input int i, input logic wn, input logic rn, input logic [31:0] addr,
                     input logic [63:0] wdata, input logic [7:0] sel);
      tbl[i].e_wen = wn; tbl[i].e_ren = rn; tbl[i].e_addr = addr;
      tbl[i].e_wdata = wdata; tbl[i].e_sel = sel;
   endtask

   task automatic sa(input int i, input logic [1:0] ak, input logic [1:0] er,
                     input logic [63:0] rdata);
      tbl[i].e_ack = ak; tbl[i].e_err = er; tbl[i].e_rdata = rdata;
   endtask

   task automatic idle_inputs();
      req_wen_i = '0; req_ren_i = '0; sys_ack_i = 1'b0; sys_err_i = 1'b0; sys_rdata_i = '0;
   endtask

   logic [31:0] hold_addr;
   logic [63:0] hold_wd;
   logic [7:0]  hold_sel;

   initial begin
      for (int i = 0; i < NV; i++) tbl[i] = '0;
      // tie read from both, r0 first; r1 read completes with bus error
      si(0, 2'b00, 2'b11, 32'h10, 32'h20, 64'h0, 1'b0, 1'b0, 64'h0);
      si(2, 2'b00, 2'b00, 32'h0, 32'h0, 64'h0, 1'b1, 1'b0, 64'hA0A0);
      sx(2, 1'b0, 1'b1, 32'h10, 64'h0, 8'hFF);
      sa(3, 2'b01, 2'b00, 64'hA0A0);
      sx(4, 1'b0, 1'b1, 32'h20, 64'h0, 8'h0F);
      si(5, 2'b00, 2'b00, 32'h0, 32'h0, 64'h0, 1'b1, 1'b1, 64'hB0B0);
      // r0 write, slave acks one cycle after the strobe
      si(6, 2'b01, 2'b00, 32'h40, 32'h0, 64'h1122334455667788, 1'b0, 1'b0, 64'h0);
      sa(6, 2'b10, 2'b10, 64'hB0B0);
      sx(8, 1'b1, 1'b0, 32'h40, 64'h1122334455667788, 8'hFF);
      si(9, 2'b00, 2'b00, 32'h0, 32'h0, 64'h0, 1'b1, 1'b0, 64'hDEAD);
      sa(10, 2'b01, 2'b00, 64'h0);
      // ack while idle must be ignored
      si(11, 2'b00, 2'b00, 32'h0, 32'h0, 64'h0, 1'b1, 1'b0, 64'h5555);
      // r1 pulses again while pending: both extra pulses dropped
      si(12, 2'b00, 2'b10, 32'h0, 32'h80, 64'h0, 1'b0, 1'b0, 64'h0);
      si(13, 2'b00, 2'b10, 32'h0, 32'h90, 64'h0, 1'b0, 1'b0, 64'h0);
      si(14, 2'b00, 2'b10, 32'h0, 32'hA0, 64'h0, 1'b0, 1'b0, 64'h0);
      sx(14, 1'b0, 1'b1, 32'h80, 64'h0, 8'h0F);
      si(15, 2'b00, 2'b00, 32'h0, 32'h0, 64'h0, 1'b1, 1'b0, 64'h1234);
      sa(16, 2'b10, 2'b00, 64'h1234);

      #1 rst_n = 1'b0;
      #11;
      chk("reset_outputs_zero", 64'(|{req_ack_o, req_err_o, req_rdata_o, sys_addr_o,
          sys_wdata_o, sys_sel_o, sys_wen_o, sys_ren_o}), 64'h0);
      tick();
      rst_n = 1'b1;

      hold_addr = '0; hold_wd = '0; hold_sel = '0;
      for (int i = 0; i < NV; i++) begin
         tick();
         if (tbl[i].e_wen || tbl[i].e_ren) begin
            hold_addr = tbl[i].e_addr; hold_wd = tbl[i].e_wdata; hold_sel = tbl[i].e_sel;
         end
         chk($sformatf("v%0d_strobe", i), {sys_wen_o, sys_ren_o}, {tbl[i].e_wen, tbl[i].e_ren});
         chk($sformatf("v%0d_addr", i), sys_addr_o, hold_addr);
         chk($sformatf("v%0d_wdata", i), sys_wdata_o, hold_wd);
         chk($sformatf("v%0d_sel", i), sys_sel_o, hold_sel);
         chk($sformatf("v%0d_ack", i), req_ack_o, tbl[i].e_ack);
         chk($sformatf("v%0d_err", i), req_err_o, tbl[i].e_err);
         chk($sformatf("v%0d_rdata", i), req_rdata_o, tbl[i].e_rdata);
         req_wen_i   = tbl[i].wen;
         req_ren_i   = tbl[i].ren;
         req_addr_i  = {tbl[i].a1, tbl[i].a0};
         req_wdata_i = {64'h0, tbl[i].wd0};
         sys_ack_i   = tbl[i].ack;
         sys_err_i   = tbl[i].err;
         sys_rdata_i = tbl[i].rd;
      end

      // round-robin alternation with re-requests in the ack cycle
      begin
         logic [31:0] exp_seq [4];
         int nstb, last_stb, n0, n1;
         exp_seq[0] = 32'h100; exp_seq[1] = 32'h200; exp_seq[2] = 32'h104; exp_seq[3] = 32'h204;
         nstb = 0; last_stb = 0; n0 = 0; n1 = 0;
         tick();
         idle_inputs();
         req_ren_i = 2'b11;
         req_addr_i = {32'h200, 32'h100};
         for (int cyc = 0; cyc < 14; cyc++) begin
            tick();
            idle_inputs();
            if (req_ack_o[0]) begin
               chk("rr_rdata0", req_rdata_o, 64'(32'h100 + 4 * n0));
               n0++;
               if (n0 == 1) begin req_ren_i[0] = 1'b1; req_addr_i[31:0] = 32'h104; end
            end
            if (req_ack_o[1]) begin
               chk("rr_rdata1", req_rdata_o, 64'(32'h200 + 4 * n1));
               n1++;
               if (n1 == 1) begin req_ren_i[1] = 1'b1; req_addr_i[63:32] = 32'h204; end
            end
            if (sys_ren_o) begin
               if (nstb < 4) chk($sformatf("rr_order%0d", nstb), sys_addr_o, exp_seq[nstb]);
               if (nstb > 0) chk("rr_gap", 64'(cyc - last_stb), 64'd2);
               last_stb = cyc;
               nstb++;
               sys_ack_i = 1'b1;
               sys_rdata_i = {32'h0, sys_addr_o};
            end
         end
         chk("rr_strobes", 64'(nstb), 64'd4);
         chk("rr_acks", 64'(n0 + n1), 64'd4);
      end

      // timeout on r0, r1 queued behind it
      begin
         int s_cyc, a_cyc;
         logic seen_tmo, seen_next;
         s_cyc = -100; a_cyc = -100; seen_tmo = 1'b0; seen_next = 1'b0;
         tick();
         idle_inputs();
         req_ren_i = 2'b01; req_addr_i[31:0] = 32'h300;
         tick();
         idle_inputs();
         req_ren_i = 2'b10; req_addr_i[63:32] = 32'h400;
         for (int cyc = 0; cyc < 16; cyc++) begin
            tick();
            idle_inputs();
            if (req_ack_o[0]) begin
               seen_tmo = 1'b1;
               a_cyc = cyc;
               chk("tmo_latency", 64'(cyc - s_cyc), 64'd9);
               chk("tmo_err", req_err_o, 2'b01);
               chk("tmo_rdata", req_rdata_o, 64'h0);
            end
            if (req_ack_o[1]) begin
               seen_next = 1'b1;
               chk("tmo_next_err", req_err_o, 2'b00);
               chk("tmo_next_rdata", req_rdata_o, 64'h4444);
            end
            if (sys_ren_o && sys_addr_o == 32'h300) s_cyc = cyc;
            if (sys_ren_o && sys_addr_o == 32'h400) begin
               chk("tmo_next_issue", 64'(cyc - a_cyc), 64'd1);
               sys_ack_i = 1'b1;
               sys_rdata_i = 64'h4444;
            end
         end
         chk("tmo_seen", 64'(seen_tmo), 64'd1);
         chk("tmo_next_seen", 64'(seen_next), 64'd1);
      end

      // reset in the middle of an access
      begin
         int nack;
         nack = 0;
         tick();
         idle_inputs();
         req_ren_i = 2'b01; req_addr_i[31:0] = 32'h500;
         tick();
         idle_inputs();
         tick();
         chk("rst_pre_strobe", {sys_ren_o, sys_addr_o}, {1'b1, 32'h500});
         #3 rst_n = 1'b0;
         #1;
         chk("rst_async_zero", 64'(|{req_ack_o, req_err_o, req_rdata_o, sys_addr_o,
             sys_wdata_o, sys_sel_o, sys_wen_o, sys_ren_o}), 64'h0);
         tick();
         sys_ack_i = 1'b1;
         tick();
         rst_n = 1'b1;
         for (int cyc = 0; cyc < 6; cyc++) begin
            tick();
            sys_ack_i = 1'b0;
            if (req_ack_o != 2'b00 || sys_ren_o || sys_wen_o) nack++;
         end
         chk("rst_no_ack", 64'(nack), 64'd0);
         req_ren_i = 2'b10; req_addr_i[63:32] = 32'h600;
         tick();
         idle_inputs();
         chk("rst_new_n1", {sys_wen_o, sys_ren_o}, 2'b00);
         tick();
         chk("rst_new_strobe", {sys_ren_o, sys_addr_o}, {1'b1, 32'h600});
         sys_ack_i = 1'b1; sys_rdata_i = 64'h77;
         tick();
         idle_inputs();
         chk("rst_new_ack", {req_ack_o, req_err_o}, 4'b1000);
         chk("rst_new_rdata", req_rdata_o, 64'h77);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
